arbiter_merge_rr: RTL and testbench
===================================

// Module: arbiter_merge_rr
// PURPOSE
//  N-channel clocked merge for spike/event packets: arbitrates NUM_CH valid/ready input channels onto one output.
//  Output passes through a DEPTH-entry FIFO; each word carries its source channel index.
//  Synchronous successor of the 2-input random-choice CSP merge; fans in neuron-core event streams to the router.
// PARAMETERS
//  NUM_CH    4  number of input channels (>=2)
//  WIDTH     8  payload bits per channel
//  DEPTH     2  output FIFO entries (>=1)
//  PRIO_MODE 0  0 = round-robin, 1 = fixed priority (lowest index wins)
//  SRC_W     $clog2(NUM_CH)  derived localparam, width of source index
// PORTS
//  clk       in   1             clock, all state on rising edge
//  rst       in   1             asynchronous, active-high reset
//  in_valid  in   NUM_CH        per-channel valid
//  in_data   in   NUM_CH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//  in_ready  out  NUM_CH        per-channel ready, one-hot or zero
//  out_valid out  1             FIFO head valid
//  out_data  out  WIDTH         FIFO head payload
//  out_src   out  SRC_W         FIFO head source channel index
//  out_ready in   1             downstream accept
//  stat_*    out  see CONFIG    present only with ARB_MERGE_STATS_EN
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO empty, out_valid=0, out_data=0, out_src=0, rr_ptr=0, stats=0.
//  - Handshake: transfer on in_valid[i]&in_ready[i] (input) or out_valid&out_ready (output).
//  - Valid must not drop before transfer; data stable while valid.
//  - space = (count<DEPTH) | (out_ready & out_valid); full with simultaneous pop still accepts.
//  - grant: one-hot over in_valid, combinational; in_ready = grant & {NUM_CH{space}}; no valid -> in_ready=0.
//  - PRIO_MODE=0: search starts at rr_ptr, wraps mod NUM_CH; on accept from ch i, rr_ptr <= (i+1)%NUM_CH.
//  - rr_ptr holds when nothing is accepted; wrap from NUM_CH-1 goes to 0.
//  - PRIO_MODE=1: lowest asserted index granted; rr_ptr unused (stays 0).
//  - Accepted word {src=i, data} written at FIFO tail; visible on out_* next cycle (latency 1).
//  - Throughput: 1 word/cycle sustained when out_ready=1.
//  - FIFO: circular, wr/rd pointers wrap at DEPTH; count updates +1 push, -1 pop, 0 both.
//  - Empty: out_valid=0, out_data/out_src hold last popped value (0 after reset).
//  - Full without pop: all in_ready=0, no pointer/arbiter change.
//  - Round-robin fairness: with all channels valid, each channel is granted once in every NUM_CH accepts.
//  - Reset mid-operation: FIFO contents discarded, any in-flight handshake void.
// CONFIGURATION
//  ARB_MERGE_STATS_EN defined: adds outputs stat_grants[NUM_CH*16] and stat_conflicts[16].
//    stat_grants: per-channel accepted-word counters, i at [i*16 +: 16].
//    stat_conflicts: counts cycles with >=2 in_valid and space=1.
//    Counters saturate at 16'hFFFF; cleared by rst.
//  Not defined: no stat_* ports or counters; data path identical.
// TESTING
//  1 Reset: assert rst mid-stream with FIFO full -> out_valid=0, in_ready=0, next grant from ch0.
//  2 Single: in_valid=4'b0100, data=8'h5A, out_ready=1 -> in_ready=4'b0100; next cycle out_data=5A, out_src=2.
//  3 RR all-valid: in_valid=4'b1111, out_ready=1, 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3.
//  4 Back-pressure: out_ready=0, DEPTH=2 -> 2 accepts then in_ready=0; out_ready=1 -> pop+push same cycle, no loss.
//  5 Fixed prio PRIO_MODE=1, in_valid=4'b1010 for 3 cycles -> out_src 1,1,1; ch3 accepted after ch1 drops.
//  6 STATS_EN, test 3 run -> stat_grants each =2, stat_conflicts=8; scoreboard checks order/no drop everywhere.

Source files
------------

// File: rtl/arbiter_merge_rr_if.sv
// arbiter_merge_rr_if: NUM_CH valid/ready input channels plus the merged, source-tagged output stream
interface arbiter_merge_rr_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int SRC_W  = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SRC_W-1:0]        out_src;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_src);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_src);
endinterface

// File: rtl/arbiter_merge_rr.sv
// arbiter_merge_rr: round-robin/fixed-priority N-channel merge into a DEPTH-entry FIFO; ARB_MERGE_STATS_EN adds stat counters
module arbiter_merge_rr #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2,
  parameter int PRIO_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  arbiter_merge_rr_if.slave    bus
`ifdef ARB_MERGE_STATS_EN
  ,
  output logic [NUM_CH*16-1:0] stat_grants,
  output logic [15:0]          stat_conflicts
`endif
);
  localparam int SRC_W = $clog2(NUM_CH);
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [SRC_W-1:0] r_src  [DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic [SRC_W-1:0] r_rr;
  logic [WIDTH-1:0] r_last_data;
  logic [SRC_W-1:0] r_last_src;
  logic [NUM_CH-1:0] w_grant;
  logic [SRC_W-1:0]  w_gidx;
  logic              w_found, w_ov, w_pop, w_space, w_push;
  always_comb begin : p_arb
    logic [SRC_W-1:0] idx;
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = PRIO_MODE != 0 ? SRC_W'(k) : SRC_W'((int'(r_rr) + k) % NUM_CH);
      if (!w_found && bus.in_valid[idx]) begin
        w_found      = 1'b1;
        w_grant[idx] = 1'b1;
        w_gidx       = idx;
      end
    end
  end
  assign w_ov          = r_cnt != '0;
  assign w_pop         = w_ov & bus.out_ready;
  assign w_space       = (r_cnt < CNT_W'(DEPTH)) | w_pop;
  // a handshake seen while reset is held is void, so ready is masked too
  assign w_push        = w_found & w_space & ~rst;
  assign bus.in_ready  = w_grant & {NUM_CH{w_space & ~rst}};
  assign bus.out_valid = w_ov;
  assign bus.out_data  = w_ov ? r_data[r_rd] : r_last_data;
  assign bus.out_src   = w_ov ? r_src[r_rd] : r_last_src;
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr] <= bus.in_data[w_gidx*WIDTH +: WIDTH];
      r_src[r_wr]  <= w_gidx;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_cnt       <= '0;
      r_rr        <= '0;
      r_last_data <= '0;
      r_last_src  <= '0;
    end else begin
      if (w_push) r_wr <= r_wr == PTR_W'(DEPTH - 1) ? '0 : r_wr + 1'b1;
      if (w_pop) begin
        r_rd        <= r_rd == PTR_W'(DEPTH - 1) ? '0 : r_rd + 1'b1;
        r_last_data <= r_data[r_rd];
        r_last_src  <= r_src[r_rd];
      end
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push && PRIO_MODE == 0) r_rr <= w_gidx == SRC_W'(NUM_CH - 1) ? '0 : w_gidx + 1'b1;
    end
  end
`ifdef ARB_MERGE_STATS_EN
  logic [15:0] r_grants [NUM_CH];
  logic [15:0] r_conf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) r_grants[i] <= '0;
      r_conf <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (w_push && w_gidx == SRC_W'(i) && r_grants[i] != 16'hFFFF) r_grants[i] <= r_grants[i] + 1'b1;
      if ($countones(bus.in_valid) >= 2 && w_space && r_conf != 16'hFFFF) r_conf <= r_conf + 1'b1;
    end
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
    assign stat_grants[g*16 +: 16] = r_grants[g];
  end
  assign stat_conflicts = r_conf;
`endif
endmodule

// File: tb/tb_arbiter_merge_rr.sv
// tb_arbiter_merge_rr: directed vector table plus random traffic against a queue-based reference for RR and fixed-priority instances
module tb_arbiter_merge_rr;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 2;
  localparam int SRC_W  = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [NUM_CH-1:0]       tv [2];
  logic [NUM_CH*WIDTH-1:0] td [2];
  logic                    tr [2];
  logic [NUM_CH-1:0]       gr [2];
  logic                    ov [2];
  logic [WIDTH-1:0]        od [2];
  logic [SRC_W-1:0]        os [2];
  arbiter_merge_rr_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) b0 ();
  arbiter_merge_rr_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) b1 ();
  assign b0.in_valid  = tv[0];
  assign b0.in_data   = td[0];
  assign b0.out_ready = tr[0];
  assign b1.in_valid  = tv[1];
  assign b1.in_data   = td[1];
  assign b1.out_ready = tr[1];
  assign gr[0] = b0.in_ready;
  assign ov[0] = b0.out_valid;
  assign od[0] = b0.out_data;
  assign os[0] = b0.out_src;
  assign gr[1] = b1.in_ready;
  assign ov[1] = b1.out_valid;
  assign od[1] = b1.out_data;
  assign os[1] = b1.out_src;
`ifdef ARB_MERGE_STATS_EN
  logic [NUM_CH*16-1:0] sg [2];
  logic [15:0]          sc [2];
  arbiter_merge_rr #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .PRIO_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0), .stat_grants(sg[0]), .stat_conflicts(sc[0]));
  arbiter_merge_rr #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .PRIO_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .stat_grants(sg[1]), .stat_conflicts(sc[1]));
`else
  arbiter_merge_rr #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .PRIO_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0));
  arbiter_merge_rr #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .PRIO_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1));
`endif
  int n_vec = 0;
  int n_bad = 0;
  logic [SRC_W+WIDTH-1:0] q0 [$];
  logic [SRC_W+WIDTH-1:0] q1 [$];
  logic [SRC_W+WIDTH-1:0] last [2];
  int                     rr [2];
  logic [NUM_CH-1:0]      acc [2];
  typedef struct {
    bit          do_rst;
    int          m;
    logic [3:0]  v;
    logic [31:0] d;
    logic        r;
    logic [3:0]  ir;
    logic        ov;
    logic [1:0]  src;
    logic [7:0]  dat;
    bit          st;
  } vec_t;
  vec_t tbl [$];
  task automatic check(input int m, input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", tag, m, $time, act, exp);
    end
  endtask
  function automatic int qsize(input int m);
    return m == 0 ? q0.size() : q1.size();
  endfunction
  function automatic logic [SRC_W+WIDTH-1:0] head(input int m);
    return m == 0 ? q0[0] : q1[0];
  endfunction
  function automatic int mgrant(input int m);
    int c;
    for (int k = 0; k < NUM_CH; k++) begin
      c = m == 1 ? k : (rr[m] + k) % NUM_CH;
      if (tv[m][c]) return c;
    end
    return -1;
  endfunction
  function automatic bit mspace(input int m);
    return qsize(m) < DEPTH || (tr[m] && qsize(m) > 0);
  endfunction
  task automatic model_clear();
    q0.delete();
    q1.delete();
    for (int m = 0; m < 2; m++) begin
      rr[m] = 0;
      last[m] = '0;
      acc[m] = '0;
    end
  endtask
  task automatic model_check(input int m);
    int g;
    logic [NUM_CH-1:0] eir;
    g = mgrant(m);
    eir = '0;
    if (g >= 0 && mspace(m) && !rst) eir[g] = 1'b1;
    check(m, "in_ready", 32'(gr[m]), 32'(eir));
    check(m, "out_valid", 32'(ov[m]), 32'(qsize(m) > 0));
    check(m, "out_word", 32'({os[m], od[m]}), 32'(qsize(m) > 0 ? head(m) : last[m]));
  endtask
  task automatic model_step(input int m);
    int g;
    bit sp;
    g = mgrant(m);
    sp = mspace(m);
    acc[m] = '0;
    if (qsize(m) > 0 && tr[m]) begin
      last[m] = head(m);
      if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (g >= 0 && sp) begin
      if (m == 0) q0.push_back({SRC_W'(g), td[m][g*WIDTH +: WIDTH]});
      else        q1.push_back({SRC_W'(g), td[m][g*WIDTH +: WIDTH]});
      acc[m][g] = 1'b1;
      if (m == 0) rr[0] = (g + 1) % NUM_CH;
    end
  endtask
  task automatic advance();
    model_check(0);
    model_check(1);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask
  task automatic cycle();
    @(negedge clk);
    advance();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    for (int m = 0; m < 2; m++) begin
      tv[m] = '0;
      td[m] = '0;
      tr[m] = 1'b1;
    end
    model_clear();
    // round-robin, back-pressure and fixed-priority vectors; rows run on dut m, the other idles
    tbl.push_back('{1, 0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b0, 2'd0, 8'h00, 0});
    tbl.push_back('{0, 0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 2'd0, 8'hA0, 0});
    tbl.push_back('{0, 0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 2'd1, 8'hA1, 0});
    tbl.push_back('{0, 0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 2'd2, 8'hA2, 0});
    tbl.push_back('{0, 0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 2'd3, 8'hA3, 0});
    tbl.push_back('{0, 0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 2'd0, 8'hA0, 0});
    tbl.push_back('{0, 0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 2'd1, 8'hA1, 0});
    tbl.push_back('{0, 0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 2'd2, 8'hA2, 0});
    tbl.push_back('{0, 0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 2'd3, 8'hA3, 1});
    tbl.push_back('{0, 0, 4'b0100, 32'h005A0000, 1'b1, 4'b0100, 1'b0, 2'd3, 8'hA3, 0});
    tbl.push_back('{0, 0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 2'd2, 8'h5A, 0});
    tbl.push_back('{0, 0, 4'b0011, 32'h0000B1B0, 1'b0, 4'b0001, 1'b0, 2'd2, 8'h5A, 0});
    tbl.push_back('{0, 0, 4'b0011, 32'h0000B1B0, 1'b0, 4'b0010, 1'b1, 2'd0, 8'hB0, 0});
    tbl.push_back('{0, 0, 4'b0011, 32'h0000B1B0, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hB0, 0});
    tbl.push_back('{0, 0, 4'b0011, 32'h0000B1B0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hB0, 0});
    tbl.push_back('{0, 0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 2'd1, 8'hB1, 0});
    tbl.push_back('{0, 0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 2'd0, 8'hB0, 0});
    tbl.push_back('{0, 0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hB0, 0});
    tbl.push_back('{1, 1, 4'b1010, 32'hC300C100, 1'b1, 4'b0010, 1'b0, 2'd0, 8'h00, 0});
    tbl.push_back('{0, 1, 4'b1010, 32'hC300C100, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hC1, 0});
    tbl.push_back('{0, 1, 4'b1010, 32'hC300C100, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hC1, 0});
    tbl.push_back('{0, 1, 4'b1000, 32'hC300C100, 1'b1, 4'b1000, 1'b1, 2'd1, 8'hC1, 0});
    tbl.push_back('{0, 1, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 2'd3, 8'hC3, 0});
    tbl.push_back('{0, 1, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'hC3, 0});
    // reset with the FIFO full and all channels still requesting
    do_reset();
    check(0, "rst_out_valid", 32'(ov[0]), 32'd0);
    check(0, "rst_out_word", 32'({os[0], od[0]}), 32'd0);
    tv[0] = 4'b1111;
    td[0] = 32'hA3A2A1A0;
    tr[0] = 1'b0;
    cycle();
    cycle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check(0, "midrst_in_ready", 32'(gr[0]), 32'd0);
    check(0, "midrst_out_valid", 32'(ov[0]), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tr[0] = 1'b1;
    @(negedge clk);
    check(0, "post_rst_grant", 32'(gr[0]), 32'b0001);
    advance();
    foreach (tbl[i]) begin
      if (tbl[i].do_rst) do_reset();
      for (int m = 0; m < 2; m++) begin
        tv[m] = m == tbl[i].m ? tbl[i].v : '0;
        td[m] = m == tbl[i].m ? tbl[i].d : '0;
        tr[m] = m == tbl[i].m ? tbl[i].r : 1'b1;
      end
      @(negedge clk);
      check(tbl[i].m, "tbl_in_ready", 32'(gr[tbl[i].m]), 32'(tbl[i].ir));
      check(tbl[i].m, "tbl_out_valid", 32'(ov[tbl[i].m]), 32'(tbl[i].ov));
      check(tbl[i].m, "tbl_out_src", 32'(os[tbl[i].m]), 32'(tbl[i].src));
      check(tbl[i].m, "tbl_out_data", 32'(od[tbl[i].m]), 32'(tbl[i].dat));
`ifdef ARB_MERGE_STATS_EN
      if (tbl[i].st) begin
        for (int c = 0; c < NUM_CH; c++) check(0, "stat_grant", 32'(sg[0][c*16 +: 16]), 32'd2);
        check(0, "stat_conflicts", 32'(sc[0]), 32'd8);
      end
`endif
      advance();
    end
    // random traffic: a valid channel holds its word until the model sees it accepted
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int m = 0; m < 2; m++) begin
        for (int c = 0; c < NUM_CH; c++)
          if (!tv[m][c] || acc[m][c]) begin
            tv[m][c] = 1'($urandom_range(0, 1));
            td[m][c*WIDTH +: WIDTH] = WIDTH'($urandom);
          end
        tr[m] = $urandom_range(0, 3) != 0;
      end
      if (n == 300) do_reset();
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
